adsr_envelope_gen: RTL

//  Per-voice ADSR envelope generator, directly downstream of the AXI-lite control/status register block.

---
 rtl/adsr_envelope_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/adsr_envelope_gen.sv
// Per-voice exponential ADSR envelope; `define ADSR_LINEAR_ATTACK_EN selects a constant-step attack.
// Latency: acc/env_out update on the clock that samples sample_tick; env_valid is high the cycle after.
// Backpressure: none; a gate edge coinciding with sample_tick takes priority and that tick is dropped.
module adsr_envelope_gen #(
    parameter int C_ACC_WIDTH = 24,
    parameter int C_ENV_WIDTH = 16
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_areset,
    input  logic                   sample_tick,
    input  logic                   note_on,
    input  logic [4:0]             attack_tau,
    input  logic [4:0]             decay_tau,
    input  logic [4:0]             release_tau,
    input  logic [7:0]             sustain_lvl,
    output logic [C_ENV_WIDTH-1:0] env_out,
    output logic                   env_valid,
    output logic                   env_active,
    output logic [2:0]             env_state
);

    localparam int AW = C_ACC_WIDTH;
    localparam logic [AW-1:0] ACC_MAX = {AW{1'b1}};
    localparam logic [AW-1:0] ACC_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ACC_ZERO = '0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t        state;
    state_t        nxt_state;
    logic          gate_q;
    logic          gate_rise;
    logic          gate_fall;
    logic          state_illegal;
    logic [AW-1:0] acc;
    logic [AW-1:0] nxt_acc;
    logic [AW-1:0] sus_acc;

    logic [AW-1:0] atk_d, atk_step, atk_room, atk_next;
    logic [AW-1:0] dec_gap, dec_d, dec_step, dec_next;
    logic [AW-1:0] rel_d, rel_step, rel_next;

    assign sus_acc       = {sustain_lvl, {(AW-8){1'b0}}};
    assign gate_rise     = note_on & ~gate_q;
    assign gate_fall     = ~note_on & gate_q;
    assign state_illegal = (state > ST_RELEASE);
    assign env_state     = state;

    // Every step is floored at 1 so small time constants and tiny residues still converge.
    always_comb begin
`ifdef ADSR_LINEAR_ATTACK_EN
        atk_d    = {1'b1, {(AW-1){1'b0}}} >> attack_tau;
`else
        atk_d    = (ACC_MAX - acc) >> attack_tau;
`endif
        atk_step = (atk_d == ACC_ZERO) ? ACC_ONE : atk_d;
        atk_room = ACC_MAX - acc;
        atk_next = (atk_step >= atk_room) ? ACC_MAX : acc + atk_step;

        // A zero gap (acc already at or below sustain) snaps straight onto the sustain level.
        dec_gap  = (acc > sus_acc) ? acc - sus_acc : ACC_ZERO;
        dec_d    = dec_gap >> decay_tau;
        dec_step = (dec_d == ACC_ZERO) ? ACC_ONE : dec_d;
        dec_next = (dec_gap <= dec_step) ? sus_acc : acc - dec_step;

        rel_d    = acc >> release_tau;
        rel_step = (rel_d == ACC_ZERO) ? ACC_ONE : rel_d;
        rel_next = (acc <= rel_step) ? ACC_ZERO : acc - rel_step;
    end

    always_comb begin
        nxt_state = ST_IDLE;
        nxt_acc   = ACC_ZERO;
        case (state)
            ST_IDLE: begin
                nxt_state = ST_IDLE;
                nxt_acc   = ACC_ZERO;
            end
            ST_ATTACK: begin
                nxt_acc   = atk_next;
                nxt_state = (atk_next == ACC_MAX) ? ST_DECAY : ST_ATTACK;
            end
            ST_DECAY: begin
                nxt_acc   = dec_next;
                nxt_state = (dec_next == sus_acc) ? ST_SUSTAIN : ST_DECAY;
            end
            ST_SUSTAIN: begin
                nxt_acc   = sus_acc;
                nxt_state = ST_SUSTAIN;
            end
            ST_RELEASE: begin
                nxt_acc   = rel_next;
                nxt_state = (rel_next == ACC_ZERO) ? ST_IDLE : ST_RELEASE;
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_acc   = ACC_ZERO;
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state      <= ST_IDLE;
            acc        <= ACC_ZERO;
            gate_q     <= 1'b0;
            env_out    <= '0;
            env_valid  <= 1'b0;
            env_active <= 1'b0;
        end else begin
            gate_q    <= note_on;
            env_valid <= 1'b0;
            if (state_illegal) begin
                state      <= ST_IDLE;
                acc        <= ACC_ZERO;
                env_out    <= '0;
                env_active <= 1'b0;
            end else if (gate_rise) begin
                // Retrigger keeps the current level so the attack ramps from wherever we are.
                state      <= ST_ATTACK;
                env_active <= 1'b1;
            end else if (gate_fall && (state == ST_ATTACK || state == ST_DECAY ||
                                       state == ST_SUSTAIN)) begin
                state      <= ST_RELEASE;
                env_active <= 1'b1;
            end else if (sample_tick) begin
                state      <= nxt_state;
                acc        <= nxt_acc;
                env_out    <= nxt_acc[AW-1 -: C_ENV_WIDTH];
                env_valid  <= 1'b1;
                env_active <= (nxt_state != ST_IDLE);
            end
        end
    end

endmodule
